// File: rtl/fpu_addsub_arbiter.sv
// Purpose   : round-robin share of one external fp16 add/sub unit between NUM_REQ requesters.
// Latency   : request accepted at edge T -> operands registered, adder evaluated, respValid from edge T+1.
// Backpress : one operation in flight; no request accepted until the response handshake completes.
//
// Ports: clock/reset (sync, active-high); reqValid/reqReady/reqIn1/reqIn2/reqSub per requester;
//        fpuIn1/fpuIn2/sub/op drive the shared adder, fpuOut/condCodes come back from it;
//        respValid/respReady/respData/respCC/respId response channel; busy = not idle.

package fpu_addsub_arbiter_pkg;
    typedef logic [15:0] fp16_t;
    typedef enum logic {
        FPU_ADD = 1'b0,
        FPU_SUB = 1'b1
    } fpuOp_t;
endpackage

module fpu_addsub_arbiter
    import fpu_addsub_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    reqValid,
    output logic [NUM_REQ-1:0]    reqReady,
    input  fp16_t [NUM_REQ-1:0]   reqIn1,
    input  fp16_t [NUM_REQ-1:0]   reqIn2,
    input  logic [NUM_REQ-1:0]    reqSub,
    output fp16_t                 fpuIn1,
    output fp16_t                 fpuIn2,
    output logic                  sub,
    output fpuOp_t                op,
    input  fp16_t                 fpuOut,
    input  logic [3:0]            condCodes,
    output logic                  respValid,
    input  logic                  respReady,
    output fp16_t                 respData,
    output logic [3:0]            respCC,
    output logic [ID_W-1:0]       respId,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    fp16_t           in1_q, in1_d;
    fp16_t           in2_q, in2_d;
    logic            sub_q, sub_d;
    logic            resp_vld_q, resp_vld_d;
    fp16_t           resp_dat_q, resp_dat_d;
    logic [3:0]      resp_cc_q, resp_cc_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;

    logic [ID_W-1:0] grant;
    logic            grant_vld;
    logic [ID_W-1:0] idx;

    // Scan offsets from the highest down so the last hit, i.e. the one
    // closest to rr_ptr_q going upward with wrap, is the one kept.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (reqValid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_id_d   = gnt_id_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        sub_d      = sub_q;
        resp_vld_d = resp_vld_q;
        resp_dat_d = resp_dat_q;
        resp_cc_d  = resp_cc_q;
        resp_id_d  = resp_id_q;
        reqReady   = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    reqReady[grant] = 1'b1;
                    in1_d    = reqIn1[grant];
                    in2_d    = reqIn2[grant];
                    sub_d    = reqSub[grant];
                    gnt_id_d = grant;
                    rr_ptr_d = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Operands have been stable for the whole cycle; sample the adder.
                resp_dat_d = fpuOut;
                resp_cc_d  = condCodes;
                resp_id_d  = gnt_id_q;
                resp_vld_d = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                if (respReady) begin
                    resp_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_id_q   <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            sub_q      <= 1'b0;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            resp_cc_q  <= '0;
            resp_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_id_q   <= gnt_id_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            sub_q      <= sub_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            resp_cc_q  <= resp_cc_d;
            resp_id_q  <= resp_id_d;
        end
    end

    assign fpuIn1    = in1_q;
    assign fpuIn2    = in2_q;
    assign sub       = sub_q;
    assign op        = sub_q ? FPU_SUB : FPU_ADD;
    assign respValid = resp_vld_q;
    assign respData  = resp_dat_q;
    assign respCC    = resp_cc_q;
    assign respId    = resp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Purpose   : self-checking bench for fpu_addsub_arbiter with a stand-in fp16 adder.
// Latency   : expects respValid one edge after the accepting edge.
// Backpress : exercises held responses and random respReady.

module tb_fpu_addsub_arbiter;
    import fpu_addsub_arbiter_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                         clock = 1'b0;
    logic                         reset;
    logic [NUM_REQ-1:0]           reqValid;
    logic [NUM_REQ-1:0]           reqReady;
    logic [NUM_REQ-1:0][15:0]     reqIn1;
    logic [NUM_REQ-1:0][15:0]     reqIn2;
    logic [NUM_REQ-1:0]           reqSub;
    logic [15:0]                  fpuIn1;
    logic [15:0]                  fpuIn2;
    logic                         sub;
    fpuOp_t                       op;
    logic [15:0]                  fpuOut;
    logic [3:0]                   condCodes;
    logic                         respValid;
    logic                         respReady;
    logic [15:0]                  respData;
    logic [3:0]                   respCC;
    logic [ID_W-1:0]              respId;
    logic                         busy;

    always #5 clock = ~clock;

    fpu_addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqIn1    (reqIn1),
        .reqIn2    (reqIn2),
        .reqSub    (reqSub),
        .fpuIn1    (fpuIn1),
        .fpuIn2    (fpuIn2),
        .sub       (sub),
        .op        (op),
        .fpuOut    (fpuOut),
        .condCodes (condCodes),
        .respValid (respValid),
        .respReady (respReady),
        .respData  (respData),
        .respCC    (respCC),
        .respId    (respId),
        .busy      (busy)
    );

    // Stand-in adder: exact fp16 results for the named cases, integer
    // add/sub of the bit patterns otherwise (only routing is under test).
    function automatic logic [15:0] fp_model(input logic [15:0] a, input logic [15:0] b, input logic s);
        case ({a, b, s})
            {16'h3C00, 16'h4000, 1'b0}: return 16'h4200;
            {16'h4400, 16'h4000, 1'b0}: return 16'h4600;
            {16'h4400, 16'h4C40, 1'b0}: return 16'h4D40;
            {16'h4400, 16'h4000, 1'b1}: return 16'h4000;
            {16'h3C00, 16'h3C00, 1'b1}: return 16'h0000;
            default:                    return s ? (a - b) : (a + b);
        endcase
    endfunction

    // ZCNV: Z on +/-0, N from sign, C/V unused by the stand-in.
    function automatic logic [3:0] cc_model(input logic [15:0] r);
        return {(r[14:0] == 15'd0), 1'b0, r[15], 1'b0};
    endfunction

    always_comb begin
        fpuOut    = fp_model(fpuIn1, fpuIn2, sub);
        condCodes = cc_model(fpuOut);
    end

    typedef struct packed {
        logic [15:0]     d;
        logic [3:0]      cc;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t             sb[$];
    logic [ID_W-1:0]  grant_log[$];
    int               n_tests = 0;
    int               n_fail  = 0;

    // Scoreboard: push on an observed accept, pop on an observed response handshake.
    task automatic monitor();
        exp_t            e;
        logic [ID_W-1:0] j;
        forever begin
            @(negedge clock);
            if (!reset) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    j = ID_W'(i);
                    if (reqValid[j] && reqReady[j]) begin
                        e.d  = fp_model(reqIn1[j], reqIn2[j], reqSub[j]);
                        e.cc = cc_model(e.d);
                        e.id = j;
                        sb.push_back(e);
                        grant_log.push_back(j);
                    end
                end
                n_tests++;
                if (((reqReady & ~reqValid) != '0) || ($countones(reqReady) > 1)) begin
                    n_fail++;
                    $display("FAIL rdy_legal: reqReady=%b reqValid=%b, required one-hot subset of reqValid", reqReady, reqValid);
                end
                if (respValid && respReady) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: response data=%h id=%0d, required none outstanding", respData, respId);
                    end else begin
                        e = sb.pop_front();
                        if ({respData, respCC, respId} !== {e.d, e.cc, e.id}) begin
                            n_fail++;
                            $display("FAIL sb_resp: got data=%h cc=%b id=%0d, required data=%h cc=%b id=%0d",
                                     respData, respCC, respId, e.d, e.cc, e.id);
                        end
                    end
                end
            end
        end
    endtask

    // One clock: drop valid of whoever is accepted on this edge.
    task automatic cycle();
        logic [NUM_REQ-1:0] acc;
        #1;
        acc = reset ? '0 : (reqValid & reqReady);
        @(posedge clock);
        #1;
        reqValid = reqValid & ~acc;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        reqValid  = '0;
        respReady = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        sb.delete();
        grant_log.delete();
    endtask

    task automatic set_req(input logic [ID_W-1:0] i, input logic [15:0] a, input logic [15:0] b, input logic s);
        reqValid[i] = 1'b1;
        reqIn1[i]   = a;
        reqIn2[i]   = b;
        reqSub[i]   = s;
    endtask

    task automatic drain(input int budget, output bit ok);
        respReady = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (reqValid == '0 && !busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (respValid !== 1'b0 || busy !== 1'b0 || reqReady !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: respValid=%b busy=%b reqReady=%b, required 0 0 00", respValid, busy, reqReady);
        end
        n_tests++;
        if ({respData, respCC, respId} !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: data=%h cc=%b id=%0d, required all 0", respData, respCC, respId);
        end
        n_tests++;
        if (fpuIn1 !== 16'h0 || fpuIn2 !== 16'h0 || sub !== 1'b0 || op !== FPU_ADD) begin
            n_fail++;
            $display("FAIL reset_opnd: in1=%h in2=%h sub=%b op=%0d, required 0 0 0 FPU_ADD", fpuIn1, fpuIn2, sub, op);
        end
    endtask

    task automatic test_single();
        respReady = 1'b1;
        set_req(1'b0, 16'h3C00, 16'h4000, 1'b0);
        #1;
        n_tests++;
        if (reqReady !== 2'b01 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: reqReady=%b busy=%b, required 01 0", reqReady, busy);
        end
        cycle();
        n_tests++;
        if (busy !== 1'b1 || respValid !== 1'b0 || fpuIn1 !== 16'h3C00 || fpuIn2 !== 16'h4000) begin
            n_fail++;
            $display("FAIL single_exec: busy=%b respValid=%b in1=%h in2=%h, required 1 0 3c00 4000", busy, respValid, fpuIn1, fpuIn2);
        end
        cycle();
        n_tests++;
        if (respValid !== 1'b1 || respData !== 16'h4200 || respId !== 1'b0 || respCC !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_resp: vld=%b data=%h id=%0d cc=%b, required 1 4200 0 0000", respValid, respData, respId, respCC);
        end
        cycle();
        n_tests++;
        if (busy !== 1'b0 || respValid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b respValid=%b, required 0 0", busy, respValid);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0]     seen_d[2];
        logic [ID_W-1:0] seen_id[2];
        int              nseen;
        bit              ok;
        do_reset();
        respReady = 1'b1;
        set_req(1'b0, 16'h4400, 16'h4000, 1'b0);
        set_req(1'b1, 16'h4400, 16'h4C40, 1'b0);
        nseen = 0;
        for (int k = 0; k < 20 && nseen < 2; k++) begin
            cycle();
            if (respValid) begin
                seen_d[nseen]  = respData;
                seen_id[nseen] = respId;
                nseen++;
            end
        end
        n_tests++;
        if (nseen != 2) begin
            n_fail++;
            $display("FAIL rr_timeout: responses=%0d, required 2", nseen);
        end else begin
            n_tests++;
            if (seen_d[0] !== 16'h4600 || seen_id[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_first: data=%h id=%0d, required 4600 0", seen_d[0], seen_id[0]);
            end
            n_tests++;
            if (seen_d[1] !== 16'h4D40 || seen_id[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_second: data=%h id=%0d, required 4d40 1", seen_d[1], seen_id[1]);
            end
        end
        cycle();
        set_req(1'b0, 16'h4400, 16'h4000, 1'b0);
        set_req(1'b1, 16'h4400, 16'h4C40, 1'b0);
        #1;
        n_tests++;
        if (reqReady !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_again: reqReady=%b, required 01", reqReady);
        end
        drain(30, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rr_drain: timeout, outstanding=%0d reqValid=%b busy=%b, required drained", sb.size(), reqValid, busy);
        end
    endtask

    task automatic test_sub();
        set_req(1'b1, 16'h4400, 16'h4000, 1'b1);
        #1;
        n_tests++;
        if (reqReady !== 2'b10) begin
            n_fail++;
            $display("FAIL sub_grant: reqReady=%b, required 10", reqReady);
        end
        cycle();
        n_tests++;
        if (sub !== 1'b1 || op !== FPU_SUB) begin
            n_fail++;
            $display("FAIL sub_exec: sub=%b op=%0d, required 1 FPU_SUB", sub, op);
        end
        cycle();
        n_tests++;
        if (respValid !== 1'b1 || respData !== 16'h4000 || respId !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_resp: vld=%b data=%h id=%0d, required 1 4000 1", respValid, respData, respId);
        end
        cycle();
    endtask

    task automatic test_zero();
        set_req(1'b0, 16'h3C00, 16'h3C00, 1'b1);
        cycle();
        cycle();
        n_tests++;
        if (respValid !== 1'b1 || respData !== 16'h0000 || respCC !== 4'b1000) begin
            n_fail++;
            $display("FAIL zero_resp: vld=%b data=%h cc=%b, required 1 0000 1000", respValid, respData, respCC);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        logic [15:0]     d0;
        logic [ID_W-1:0] id0;
        bit              ok;
        do_reset();
        respReady = 1'b0;
        set_req(1'b0, 16'h4400, 16'h4000, 1'b0);
        set_req(1'b1, 16'h3C00, 16'h4000, 1'b0);
        cycle();
        cycle();
        d0  = respData;
        id0 = respId;
        n_tests++;
        if (respValid !== 1'b1 || d0 !== 16'h4600 || id0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_first: vld=%b data=%h id=%0d, required 1 4600 0", respValid, d0, id0);
        end
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_tests++;
            if (respValid !== 1'b1 || respData !== d0 || respId !== id0) begin
                n_fail++;
                $display("FAIL bp_hold: cyc=%0d vld=%b data=%h id=%0d, required 1 %h %0d", k, respValid, respData, respId, d0, id0);
            end
            n_tests++;
            if (reqReady !== 2'b00 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_block: cyc=%0d reqReady=%b busy=%b, required 00 1", k, reqReady, busy);
            end
        end
        respReady = 1'b1;
        cycle();
        respReady = 1'b0;
        #1;
        n_tests++;
        if (respValid !== 1'b0 || reqReady !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b reqReady=%b, required 0 10", respValid, reqReady);
        end
        drain(20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_drain: timeout, outstanding=%0d busy=%b, required drained", sb.size(), busy);
        end
    endtask

    task automatic test_reset_exec();
        bit rose;
        bit ok;
        do_reset();
        respReady = 1'b1;
        set_req(1'b0, 16'h4400, 16'h4000, 1'b0);
        cycle();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_exec_entry: busy=%b, required 1", busy);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        sb.delete();
        grant_log.delete();
        n_tests++;
        if (busy !== 1'b0 || respValid !== 1'b0 || {respData, respCC, respId} !== '0) begin
            n_fail++;
            $display("FAIL rst_exec_state: busy=%b vld=%b data=%h cc=%b id=%0d, required all 0", busy, respValid, respData, respCC, respId);
        end
        rose = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (respValid) rose = 1'b1;
        end
        n_tests++;
        if (rose !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exec_noresp: respValid rose=%b, required 0", rose);
        end
        set_req(1'b0, 16'h1111, 16'h2222, 1'b0);
        set_req(1'b1, 16'h3333, 16'h0444, 1'b1);
        #1;
        n_tests++;
        if (reqReady !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_exec_rrptr: reqReady=%b, required 01", reqReady);
        end
        drain(30, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rst_exec_drain: timeout, outstanding=%0d busy=%b, required drained", sb.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [ID_W-1:0] j;
        int              both_cnt;
        int              alt_bad;
        bit              ok;
        do_reset();
        both_cnt = 0;
        alt_bad  = 0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                j = ID_W'(i);
                if (!reqValid[j] && $urandom_range(0, 2) == 0)
                    set_req(j, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            end
            respReady = ($urandom_range(0, 3) != 0);
            // With both requesting in IDLE, the grant must go to the one not served last.
            #1;
            if (reqValid == 2'b11 && !busy && grant_log.size() > 0) begin
                both_cnt++;
                if (reqReady[grant_log[grant_log.size() - 1]]) alt_bad++;
            end
            cycle();
        end
        n_tests++;
        if (alt_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_fair: repeated grants=%0d of %0d contended, required 0", alt_bad, both_cnt);
        end
        drain(50, ok);
        n_tests++;
        if (!ok || grant_log.size() < 20) begin
            n_fail++;
            $display("FAIL b2b_drain: ok=%b grants=%0d outstanding=%0d, required drained and >=20 grants", ok, grant_log.size(), sb.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        reqValid  = '0;
        reqIn1    = '0;
        reqIn2    = '0;
        reqSub    = '0;
        respReady = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_sub();
        test_zero();
        test_backpressure();
        test_reset_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
